// File: rtl/a1339_position_tracker.sv
// Unwraps a time-multiplexed stream of raw angle samples into per-sensor signed multi-turn
// positions and fixed-window velocities. Optional glitch rejection: A1339_TRACKER_GLITCH_REJECT_EN.
module a1339_position_tracker #(
  parameter int NUMBER_OF_SENSORS      = 1,
  parameter int ANGLE_BITS             = 12,
  parameter int VELOCITY_WINDOW_CYCLES = 50_000,
  parameter int MAX_STEP               = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            sample_valid,
  input  logic [7:0]                      sample_sensor,
  input  logic [ANGLE_BITS-1:0]           sample_angle,
  input  logic                            sample_crc_ok,
  input  logic                            zero_offset,
  output logic                            sample_ready,
  output logic [32*NUMBER_OF_SENSORS-1:0] position,
  output logic [32*NUMBER_OF_SENSORS-1:0] velocity,
  output logic [NUMBER_OF_SENSORS-1:0]    update,
  output logic                            velocity_update,
  output logic [16*NUMBER_OF_SENSORS-1:0] error_count
);
  localparam int N  = NUMBER_OF_SENSORS;
  localparam int CW = (VELOCITY_WINDOW_CYCLES > 1) ? $clog2(VELOCITY_WINDOW_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DIFF, ACCUM} state_t;

  state_t                state;
  logic [7:0]            sensor_p0;
  logic [ANGLE_BITS-1:0] angle_p0;
  logic                  crc_p0;
  logic signed [31:0]    delta_p1;
  logic [CW-1:0]         win_cnt;
  logic                  win_end;
  logic [ANGLE_BITS-1:0] prev_sel;

  logic signed [31:0]    raw      [N];
  logic signed [31:0]    raw_nxt  [N];
  logic signed [31:0]    offset   [N];
  logic signed [31:0]    off_nxt  [N];
  logic signed [31:0]    snap     [N];
  logic signed [31:0]    pos      [N];
  logic signed [31:0]    vel      [N];
  logic [ANGLE_BITS-1:0] prev     [N];
  logic [ANGLE_BITS-1:0] prev_nxt [N];
  logic [15:0]           err      [N];
  logic [15:0]           err_nxt  [N];
  logic [N-1:0]          init;
  logic [N-1:0]          init_nxt;
  logic [N-1:0]          upd_nxt;

  // Shortest-path difference on the circle, as a signed 32-bit step.
  function automatic logic signed [31:0] wrap_delta(input logic [ANGLE_BITS-1:0] cur,
                                                    input logic [ANGLE_BITS-1:0] old);
    logic [ANGLE_BITS-1:0] d;
    d = cur - old;
    return $signed({{(32-ANGLE_BITS){d[ANGLE_BITS-1]}}, d});
  endfunction

  function automatic logic step_ok(input logic signed [31:0] d);
    return (d <= MAX_STEP) && (d >= -MAX_STEP);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign sample_ready = (state == IDLE) || reset;
  assign win_end      = (win_cnt == CW'(VELOCITY_WINDOW_CYCLES - 1));

  always_comb begin
    prev_sel = '0;
    init_nxt = init;
    upd_nxt  = '0;
    for (int k = 0; k < N; k++) begin
      raw_nxt[k]  = raw[k];
      prev_nxt[k] = prev[k];
      err_nxt[k]  = err[k];
      if (32'(sensor_p0) == k) prev_sel = prev[k];
      if (state == ACCUM && 32'(sensor_p0) == k) begin
        if (!crc_p0) begin
          err_nxt[k] = sat_inc(err[k]);
        end else if (!init[k]) begin
          raw_nxt[k]  = $signed({{(32-ANGLE_BITS){1'b0}}, angle_p0});
          prev_nxt[k] = angle_p0;
          init_nxt[k] = 1'b1;
          upd_nxt[k]  = 1'b1;
`ifdef A1339_TRACKER_GLITCH_REJECT_EN
        end else if (!step_ok(delta_p1)) begin
          err_nxt[k] = sat_inc(err[k]);
`endif
        end else begin
          raw_nxt[k]  = raw[k] + delta_p1;
          prev_nxt[k] = angle_p0;
          upd_nxt[k]  = 1'b1;
        end
      end
      // Zeroing captures the post-accumulate raw so a coincident sample reads 0 too.
      off_nxt[k] = zero_offset ? raw_nxt[k] : offset[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      sensor_p0       <= '0;
      angle_p0        <= '0;
      crc_p0          <= 1'b0;
      delta_p1        <= '0;
      win_cnt         <= '0;
      velocity_update <= 1'b0;
      update          <= '0;
      init            <= '0;
      for (int k = 0; k < N; k++) begin
        raw[k]    <= '0;
        offset[k] <= '0;
        snap[k]   <= '0;
        pos[k]    <= '0;
        vel[k]    <= '0;
        prev[k]   <= '0;
        err[k]    <= '0;
      end
    end else begin
      update          <= upd_nxt;
      init            <= init_nxt;
      velocity_update <= win_end;
      win_cnt         <= win_end ? '0 : win_cnt + CW'(1);
      for (int k = 0; k < N; k++) begin
        raw[k]    <= raw_nxt[k];
        prev[k]   <= prev_nxt[k];
        err[k]    <= err_nxt[k];
        offset[k] <= off_nxt[k];
        pos[k]    <= raw_nxt[k] - off_nxt[k];
        // Window snapshot uses the pre-update raw; a coincident sample lands in the next window.
        if (win_end) begin
          vel[k]  <= raw[k] - snap[k];
          snap[k] <= raw[k];
        end
      end
      case (state)
        // p0: capture the accepted sample
        IDLE: begin
          if (sample_valid && 32'(sample_sensor) < N) begin
            sensor_p0 <= sample_sensor;
            angle_p0  <= sample_angle;
            crc_p0    <= sample_crc_ok;
            state     <= DIFF;
          end
        end
        // p1: wrapped difference against the sensor's previous angle
        DIFF: begin
          delta_p1 <= wrap_delta(angle_p0, prev_sel);
          state    <= ACCUM;
        end
        ACCUM:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      position[32*k +: 32]    = pos[k];
      velocity[32*k +: 32]    = vel[k];
      error_count[16*k +: 16] = err[k];
    end
  end

endmodule
